// File: rtl/counter_request_source.sv
// counter_request_source
//
// Turns asynchronous plus/minus pulse trains into one-at-a-time increment
// requests for a single plus/minus counter cell. Pulses are synchronized and
// edge-detected. Their net effect is kept as a signed pending count. One unit
// at a time is moved from that count into a held request, which stays up
// until the counter cell's service strobe clears it.
//
// Ports
//   CLOCK  in   system clock, rising edge
//   rst    in   asynchronous reset, active high
//   PLSP   in   external plus pulse (async level, rising edge = +1)
//   PLSM   in   external minus pulse (async level, rising edge = -1)
//   CR     in   service strobe from the counter cell
//   GOJAM  in   synchronous restart (clears count and request, keeps flags)
//   CP     out  plus-increment request
//   CM     out  minus-increment request
//   PEND   out  signed net pending count, outstanding request excluded
//   OVF    out  sticky saturation flag
//   SPUR   out  sticky flag: CR seen with no request outstanding
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request; launches one as soon as PEND is non-zero
// REQP  | plus request held on CP until CR
// REQM  | minus request held on CM until CR
// GAP   | one mandatory quiet cycle after a serviced request
module counter_request_source #(
  parameter int CNT_W    = 4,
  parameter int MAX_PEND = 15
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic               PLSP,
  input  logic               PLSM,
  input  logic               CR,
  input  logic               GOJAM,
  output logic               CP,
  output logic               CM,
  output logic signed [CNT_W:0] PEND,
  output logic               OVF,
  output logic               SPUR
);

  // Two guard bits above PEND keep the unclamped sum exact.
  localparam int SUM_W = CNT_W + 3;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(MAX_PEND);
  localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQP = 2'd1,
    REQM = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t state, state_nx;

  // [0] = s1, [1] = s2, [2] = s3 (history)
  logic [2:0] sync_p;
  logic [2:0] sync_m;
  logic       ev_p;
  logic       ev_m;

  logic signed [SUM_W-1:0] pend_ext;
  logic signed [SUM_W-1:0] inc_p;
  logic signed [SUM_W-1:0] inc_m;
  logic signed [SUM_W-1:0] adj;
  logic signed [SUM_W-1:0] sum;
  logic signed [CNT_W:0]   pend_nx;
  logic                    ovf_set;
  logic                    spur_set;
  logic                    pend_pos;
  logic                    pend_neg;

  assign ev_p = sync_p[1] & ~sync_p[2];
  assign ev_m = sync_m[1] & ~sync_m[2];

  assign pend_neg = PEND[CNT_W];
  assign pend_pos = ~PEND[CNT_W] & (PEND != '0);

  assign CP = (state == REQP);
  assign CM = (state == REQM);

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, launch adjustment and spurious-strobe detection.
  always_comb begin
    state_nx = state;
    adj      = '0;
    spur_set = 1'b0;
    case (state)
      IDLE: begin
        spur_set = CR;
        if (pend_pos) begin
          state_nx = REQP;
          adj      = '1;
        end else if (pend_neg) begin
          state_nx = REQM;
          adj      = {{(SUM_W-1){1'b0}}, 1'b1};
        end
      end
      REQP, REQM: begin
        if (CR) state_nx = GAP;
      end
      GAP: begin
        spur_set = CR;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (GOJAM) begin
      state_nx = IDLE;
      spur_set = 1'b0;
    end
  end

  // Net pulse events plus launch adjustment, then saturate.
  always_comb begin
    pend_ext = {{(SUM_W-CNT_W-1){PEND[CNT_W]}}, PEND};
    inc_p    = {{(SUM_W-1){1'b0}}, ev_p};
    inc_m    = {{(SUM_W-1){1'b0}}, ev_m};
    sum      = pend_ext + inc_p - inc_m + adj;
    pend_nx  = sum[CNT_W:0];
    ovf_set  = 1'b0;
    if (sum > SAT_HI) begin
      pend_nx = SAT_HI[CNT_W:0];
      ovf_set = 1'b1;
    end else if (sum < SAT_LO) begin
      pend_nx = SAT_LO[CNT_W:0];
      ovf_set = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      sync_p <= '0;
      sync_m <= '0;
      PEND   <= '0;
      OVF    <= 1'b0;
      SPUR   <= 1'b0;
    end else begin
      // Synchronizers run through GOJAM so an edge in flight still lands.
      sync_p <= {sync_p[1:0], PLSP};
      sync_m <= {sync_m[1:0], PLSM};
      if (GOJAM) begin
        PEND <= '0;
      end else begin
        PEND <= pend_nx;
        if (ovf_set) OVF <= 1'b1;
      end
      if (spur_set) SPUR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_request_source.sv
module tb_counter_request_source;

  localparam int CNT_W    = 4;
  localparam int MAX_PEND = 15;

  logic               CLOCK;
  logic               rst;
  logic               PLSP;
  logic               PLSM;
  logic               CR;
  logic               GOJAM;
  logic               CP;
  logic               CM;
  logic signed [CNT_W:0] PEND;
  logic               OVF;
  logic               SPUR;

  counter_request_source #(.CNT_W(CNT_W), .MAX_PEND(MAX_PEND)) dut (
    .CLOCK(CLOCK),
    .rst  (rst),
    .PLSP (PLSP),
    .PLSM (PLSM),
    .CR   (CR),
    .GOJAM(GOJAM),
    .CP   (CP),
    .CM   (CM),
    .PEND (PEND),
    .OVF  (OVF),
    .SPUR (SPUR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: integers and a two-deep event delay queue.
  int m_pend;
  int m_req;     // +1 plus request, -1 minus request, 0 none
  bit m_gap;
  bit m_ovf;
  bit m_spur;
  bit prev_p;
  bit prev_m;
  int qp[$];
  int qm[$];

  task automatic model_reset();
    m_pend = 0; m_req = 0; m_gap = 0; m_ovf = 0; m_spur = 0;
    prev_p = 0; prev_m = 0;
    qp = '{0, 0};
    qm = '{0, 0};
  endtask

  task automatic model_step(input bit p, input bit m, input bit cr, input bit gj);
    int ep, em, take, n;
    // a sampled rising edge becomes a count change two edges later
    qp.push_back((p && !prev_p) ? 1 : 0);
    qm.push_back((m && !prev_m) ? 1 : 0);
    prev_p = p;
    prev_m = m;
    ep = qp.pop_front();
    em = qm.pop_front();
    take = 0;
    if (gj) begin
      m_pend = 0; m_req = 0; m_gap = 0;
    end else begin
      if (m_req != 0) begin
        if (cr) begin m_req = 0; m_gap = 1; end
      end else if (m_gap) begin
        m_gap = 0;
        if (cr) m_spur = 1;
      end else begin
        if (cr) m_spur = 1;
        if (m_pend > 0) begin m_req = 1; take = -1; end
        else if (m_pend < 0) begin m_req = -1; take = 1; end
      end
      n = m_pend + ep - em + take;
      if (n > MAX_PEND) begin n = MAX_PEND; m_ovf = 1; end
      else if (n < -MAX_PEND) begin n = -MAX_PEND; m_ovf = 1; end
      m_pend = n;
    end
  endtask

  task automatic tick(input logic p, input logic m, input logic cr, input logic gj);
    PLSP = p; PLSM = m; CR = cr; GOJAM = gj;
    @(posedge CLOCK);
    model_step(p, m, cr, gj);
    @(negedge CLOCK);
    chk("model_cp",   int'(CP),   (m_req == 1)  ? 1 : 0);
    chk("model_cm",   int'(CM),   (m_req == -1) ? 1 : 0);
    chk("model_pend", int'(PEND), m_pend);
    chk("model_ovf",  int'(OVF),  int'(m_ovf));
    chk("model_spur", int'(SPUR), int'(m_spur));
  endtask

  task automatic pulse(input logic p, input logic m);
    tick(p, m, 0, 0); tick(p, m, 0, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
  endtask

  task automatic async_reset_check();
    rst = 1'b1;
    #1;
    chk("arst_cp",   int'(CP),   0);
    chk("arst_cm",   int'(CM),   0);
    chk("arst_pend", int'(PEND), 0);
    chk("arst_ovf",  int'(OVF),  0);
    chk("arst_spur", int'(SPUR), 0);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic plsp; logic plsm; logic cr; logic gojam;
    logic cp;   logic cm;   int pend; logic ovf; logic spur;
  } vec_t;

  vec_t vq[$];

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rises;
    bit pending_cr;
    bit cp_last;
    logic rp, rm;
    int runp, runm;

    // single plus, service, sign reversal, spurious CR, GOJAM restart
    vq.push_back('{1,0,0,0, 0,0, 0,0,0});
    vq.push_back('{1,0,0,0, 0,0, 0,0,0});
    vq.push_back('{1,0,0,0, 0,0, 1,0,0});
    vq.push_back('{0,0,0,0, 1,0, 0,0,0});
    vq.push_back('{0,0,0,0, 1,0, 0,0,0});
    vq.push_back('{0,0,1,0, 0,0, 0,0,0});
    vq.push_back('{0,0,0,0, 0,0, 0,0,0});
    vq.push_back('{1,0,0,0, 0,0, 0,0,0});
    vq.push_back('{1,0,0,0, 0,0, 0,0,0});
    vq.push_back('{0,0,0,0, 0,0, 1,0,0});
    vq.push_back('{0,1,0,0, 1,0, 0,0,0});
    vq.push_back('{0,1,0,0, 1,0, 0,0,0});
    vq.push_back('{0,0,0,0, 1,0,-1,0,0});
    vq.push_back('{0,0,0,0, 1,0,-1,0,0});
    vq.push_back('{0,1,0,0, 1,0,-1,0,0});
    vq.push_back('{0,1,0,0, 1,0,-1,0,0});
    vq.push_back('{0,0,0,0, 1,0,-2,0,0});
    vq.push_back('{0,0,1,0, 0,0,-2,0,0});
    vq.push_back('{0,0,0,0, 0,0,-2,0,0});
    vq.push_back('{0,0,0,0, 0,1,-1,0,0});
    vq.push_back('{0,0,1,0, 0,0,-1,0,0});
    vq.push_back('{0,0,0,0, 0,0,-1,0,0});
    vq.push_back('{0,0,0,0, 0,1, 0,0,0});
    vq.push_back('{0,0,1,0, 0,0, 0,0,0});
    vq.push_back('{0,0,0,0, 0,0, 0,0,0});
    vq.push_back('{0,0,1,0, 0,0, 0,0,1});
    vq.push_back('{1,0,0,1, 0,0, 0,0,1});
    vq.push_back('{1,0,0,0, 0,0, 0,0,1});
    vq.push_back('{0,0,0,0, 0,0, 1,0,1});
    vq.push_back('{0,0,0,0, 1,0, 0,0,1});
    vq.push_back('{0,0,1,1, 0,0, 0,0,1});

    PLSP = 0; PLSM = 0; CR = 0; GOJAM = 0;
    rst = 1'b1;
    repeat (2) @(negedge CLOCK);
    rst = 1'b0;
    model_reset();
    chk("reset_cp",   int'(CP),   0);
    chk("reset_cm",   int'(CM),   0);
    chk("reset_pend", int'(PEND), 0);
    chk("reset_ovf",  int'(OVF),  0);
    chk("reset_spur", int'(SPUR), 0);

    foreach (vq[i]) begin
      tick(vq[i].plsp, vq[i].plsm, vq[i].cr, vq[i].gojam);
      chk($sformatf("vec%0d_cp", i),   int'(CP),   int'(vq[i].cp));
      chk($sformatf("vec%0d_cm", i),   int'(CM),   int'(vq[i].cm));
      chk($sformatf("vec%0d_pend", i), int'(PEND), vq[i].pend);
      chk($sformatf("vec%0d_ovf", i),  int'(OVF),  int'(vq[i].ovf));
      chk($sformatf("vec%0d_spur", i), int'(SPUR), int'(vq[i].spur));
    end

    // burst of five, then drain with CR one cycle after each CP rise
    async_reset_check();
    for (int i = 0; i < 5; i++) pulse(1, 0);
    chk("burst_pend", int'(PEND), 4);
    chk("burst_cp",   int'(CP),   1);
    rises = 0; pending_cr = 0; cp_last = 0;
    for (int c = 0; c < 40; c++) begin
      tick(0, 0, pending_cr, 0);
      pending_cr = 0;
      if (CM) chk("drain_cm_low", int'(CM), 0);
      if (CP && !cp_last) begin
        rises++;
        pending_cr = 1;
      end
      cp_last = CP;
    end
    chk("drain_rises", rises, 5);
    chk("drain_pend",  int'(PEND), 0);
    chk("drain_cp",    int'(CP),   0);
    chk("drain_spur",  int'(SPUR), 0);

    // saturation at +MAX_PEND
    async_reset_check();
    for (int i = 0; i < 20; i++) pulse(1, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("sat_pend", int'(PEND), 15);
    chk("sat_ovf",  int'(OVF),  1);
    chk("sat_cp",   int'(CP),   1);
    tick(0, 0, 0, 1);
    chk("gj_sat_pend", int'(PEND), 0);
    chk("gj_sat_cp",   int'(CP),   0);
    chk("gj_sat_ovf",  int'(OVF),  1);

    // simultaneous plus and minus edges cancel
    pulse(1, 0); pulse(1, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("pre_cancel_pend", int'(PEND), 1);
    pulse(1, 1);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("cancel_pend", int'(PEND), 1);
    chk("cancel_cp",   int'(CP),   1);

    // asynchronous reset with CP up and PEND = 3
    pulse(1, 0); pulse(1, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("pre_rst_pend", int'(PEND), 3);
    chk("pre_rst_cp",   int'(CP),   1);
    async_reset_check();
    repeat (4) tick(0, 0, 0, 0);
    chk("post_rst_cp",   int'(CP),   0);
    chk("post_rst_pend", int'(PEND), 0);

    // GOJAM with a minus request outstanding, then a spurious CR
    for (int i = 0; i < 5; i++) pulse(0, 1);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("neg_cm",   int'(CM),   1);
    chk("neg_pend", int'(PEND), -4);
    tick(0, 0, 0, 1);
    chk("gj_cm",   int'(CM),   0);
    chk("gj_pend", int'(PEND), 0);
    chk("gj_spur", int'(SPUR), 0);
    tick(0, 0, 1, 0);
    chk("spur_set",  int'(SPUR), 1);
    chk("spur_pend", int'(PEND), 0);

    // randomized traffic against the model
    async_reset_check();
    rp = 0; rm = 0; runp = 0; runm = 0;
    for (int c = 0; c < 1500; c++) begin
      if (runp >= 2 && $urandom_range(0, 2) == 0) begin rp = ~rp; runp = 0; end
      if (runm >= 2 && $urandom_range(0, 2) == 0) begin rm = ~rm; runm = 0; end
      tick(rp, rm, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      runp++;
      runm++;
    end
    repeat (4) tick(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
